// File: rtl/sram_ctrl.sv
// sram_ctrl: sequences a 32-bit masked word access into two 16-bit async SRAM halfword phases.
// Optional SRAM_HALF_SKIP_EN: halves whose two mask bits are both zero are skipped.
module sram_ctrl #(
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic        i_we,
  input  logic [16:0] i_addr,
  input  logic [3:0]  i_bmask,
  input  logic [31:0] i_wdata,
  output logic        o_ready,
  output logic        o_ack,
  output logic [31:0] o_rdata,
  output logic [17:0] o_sram_addr,
  inout  wire  [15:0] io_sram_dq,
  output logic        o_sram_we_n,
  output logic        o_sram_ce_n,
  output logic        o_sram_oe_n,
  output logic        o_sram_lb_n,
  output logic        o_sram_ub_n
);
  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;
`ifdef SRAM_HALF_SKIP_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif
  localparam logic [3:0] LAST = 4'(WAIT_CYCLES - 1);
  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [16:0] addr_q, addr_d;
  logic [3:0]  bmask_q, bmask_d;
  logic [31:0] wdata_q, wdata_d;
  logic [15:0] lo_q, lo_d;
  logic [31:0] rdata_q, rdata_d;
  logic [17:0] sram_addr_q, sram_addr_d;
  logic [15:0] dq_q, dq_d;
  logic        ce_n_q, ce_n_d, we_n_q, we_n_d, oe_n_q, oe_n_d;
  logic        lb_n_q, lb_n_d, ub_n_q, ub_n_d, ack_q, ack_d, dq_oe_q, dq_oe_d;
  logic        skip_lo, skip_hi, ph_end, phase, hi_sel;
  always_comb begin
    we_d = we_q;
    addr_d = addr_q;
    bmask_d = bmask_q;
    wdata_d = wdata_q;
    lo_d = lo_q;
    rdata_d = rdata_q;
    state_d = state_q;
    ph_end = cnt_q == LAST;
    if (state_q == IDLE && i_req) begin
      we_d = i_we;
      addr_d = i_addr;
      bmask_d = i_bmask;
      wdata_d = i_wdata;
      lo_d = '0;
    end
    skip_lo = SKIP && bmask_d[1:0] == 2'b00;
    skip_hi = SKIP && bmask_d[3:2] == 2'b00;
    case (state_q)
      IDLE:    if (i_req) state_d = skip_lo ? (skip_hi ? DONE : HI) : LO;
      LO:      if (ph_end) state_d = skip_hi ? DONE : HI;
      HI:      if (ph_end) state_d = DONE;
      default: state_d = IDLE;
    endcase
    cnt_d = (state_d == state_q && (state_q == LO || state_q == HI)) ? cnt_q + 4'd1 : 4'd0;
    if (state_q == LO && ph_end && !we_q) lo_d = io_sram_dq;
    // a skipped half leaves its rdata half at zero (lo_d cleared on accept)
    if (state_d == DONE && state_q != DONE && !we_d)
      rdata_d = {state_q == HI ? io_sram_dq : 16'h0000, lo_d};
    phase = state_d == LO || state_d == HI;
    hi_sel = state_d == HI;
    sram_addr_d = phase ? {addr_d, hi_sel} : sram_addr_q;
    ce_n_d = !phase;
    we_n_d = !(phase && we_d);
    oe_n_d = !(phase && !we_d);
    lb_n_d = !phase || (we_d && !(hi_sel ? bmask_d[2] : bmask_d[0]));
    ub_n_d = !phase || (we_d && !(hi_sel ? bmask_d[3] : bmask_d[1]));
    dq_oe_d = phase && we_d;
    dq_d = hi_sel ? wdata_d[31:16] : wdata_d[15:0];
    ack_d = state_d == DONE;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      we_q <= 1'b0;
      addr_q <= '0;
      bmask_q <= '0;
      wdata_q <= '0;
      lo_q <= '0;
      rdata_q <= '0;
      sram_addr_q <= '0;
      dq_q <= '0;
      ce_n_q <= 1'b1;
      we_n_q <= 1'b1;
      oe_n_q <= 1'b1;
      lb_n_q <= 1'b1;
      ub_n_q <= 1'b1;
      ack_q <= 1'b0;
      dq_oe_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      we_q <= we_d;
      addr_q <= addr_d;
      bmask_q <= bmask_d;
      wdata_q <= wdata_d;
      lo_q <= lo_d;
      rdata_q <= rdata_d;
      sram_addr_q <= sram_addr_d;
      dq_q <= dq_d;
      ce_n_q <= ce_n_d;
      we_n_q <= we_n_d;
      oe_n_q <= oe_n_d;
      lb_n_q <= lb_n_d;
      ub_n_q <= ub_n_d;
      ack_q <= ack_d;
      dq_oe_q <= dq_oe_d;
    end
  end
  assign io_sram_dq = dq_oe_q ? dq_q : 16'hzzzz;
  assign o_ready = state_q == IDLE;
  assign o_ack = ack_q;
  assign o_rdata = rdata_q;
  assign o_sram_addr = sram_addr_q;
  assign o_sram_ce_n = ce_n_q;
  assign o_sram_we_n = we_n_q;
  assign o_sram_oe_n = oe_n_q;
  assign o_sram_lb_n = lb_n_q;
  assign o_sram_ub_n = ub_n_q;
endmodule

// File: tb/tb_sram_ctrl.sv
// tb_sram_ctrl: three controllers (WAIT_CYCLES 1..3) against a cycle-index reference model and an SRAM model.
module tb_sram_ctrl;
`ifdef SRAM_HALF_SKIP_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif
  localparam logic [15:0] PULL = 16'hC3A5;
  logic clk = 0, rst = 1, go = 0;
  logic [2:0] req = '0;
  logic we = 0;
  logic [16:0] addr = '0;
  logic [3:0] bm = '0;
  logic [31:0] wd = '0;
  logic [2:0] rdy, ack, we_n, ce_n, oe_n, lb_n, ub_n;
  logic [31:0] rdata [3];
  logic [17:0] sa [3];
  logic [15:0] dq_m [3];
  logic [15:0] mem [3][64];
  int vectors = 0, miscompares = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 3; g++) begin : g_dut
    wire [15:0] dq;
    sram_ctrl #(.WAIT_CYCLES(g + 1)) u_dut (
      .clk(clk), .reset(rst), .i_req(req[g]), .i_we(we), .i_addr(addr), .i_bmask(bm),
      .i_wdata(wd), .o_ready(rdy[g]), .o_ack(ack[g]), .o_rdata(rdata[g]), .o_sram_addr(sa[g]),
      .io_sram_dq(dq), .o_sram_we_n(we_n[g]), .o_sram_ce_n(ce_n[g]), .o_sram_oe_n(oe_n[g]),
      .o_sram_lb_n(lb_n[g]), .o_sram_ub_n(ub_n[g]));
    // SRAM drives on output enable; otherwise a keeper pattern exposes any stray controller drive
    assign dq = we_n[g] ? ((!ce_n[g] && !oe_n[g]) ? mem[g][sa[g][5:0]] : PULL) : 16'hzzzz;
    assign dq_m[g] = dq;
  end
  task automatic chk(input string n, input int i, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s[%0d] t=%0t: got %h want %h", n, i, $time, act, exp);
    end
  endtask
  // reference model: phase from cycle index since acceptance
  bit busy [3];
  int k [3];
  bit mwe [3];
  logic [16:0] ma [3];
  logic [3:0] mm [3];
  logic [31:0] mwd [3];
  logic [31:0] erd [3];
  initial begin
    int w, lo_n, hi_n;
    bit lo, hi, dn, ph, sl, sh;
    logic [17:0] ea;
    logic [15:0] edq;
    for (int i = 0; i < 3; i++) begin
      busy[i] = 0; k[i] = 0; erd[i] = '0; mwe[i] = 0; ma[i] = '0; mm[i] = '0; mwd[i] = '0;
    end
    forever begin
      @(negedge clk);
      if (go) for (int i = 0; i < 3; i++) begin
        if (rst) begin
          busy[i] = 0;
          erd[i] = '0;
        end
        w = i + 1;
        sl = SKIP && mm[i][1:0] == 2'b00;
        sh = SKIP && mm[i][3:2] == 2'b00;
        lo_n = sl ? 0 : w;
        hi_n = sh ? 0 : w;
        lo = busy[i] && k[i] <= lo_n;
        hi = busy[i] && k[i] > lo_n && k[i] <= lo_n + hi_n;
        dn = busy[i] && k[i] == lo_n + hi_n + 1;
        ph = lo || hi;
        if (dn && !mwe[i])
          erd[i] = {sh ? 16'h0 : mem[i][{ma[i][4:0], 1'b1}], sl ? 16'h0 : mem[i][{ma[i][4:0], 1'b0}]};
        ea = {ma[i], hi};
        edq = (ph && mwe[i]) ? (hi ? mwd[i][31:16] : mwd[i][15:0]) : (ph ? mem[i][ea[5:0]] : PULL);
        chk("ready", i, 32'(rdy[i]), 32'(!busy[i]));
        chk("ack", i, 32'(ack[i]), 32'(dn));
        chk("ce_n", i, 32'(ce_n[i]), 32'(!ph));
        chk("we_n", i, 32'(we_n[i]), 32'(!(ph && mwe[i])));
        chk("oe_n", i, 32'(oe_n[i]), 32'(!(ph && !mwe[i])));
        chk("lb_n", i, 32'(lb_n[i]), 32'(!ph || (mwe[i] && !(hi ? mm[i][2] : mm[i][0]))));
        chk("ub_n", i, 32'(ub_n[i]), 32'(!ph || (mwe[i] && !(hi ? mm[i][3] : mm[i][1]))));
        chk("rdata", i, rdata[i], erd[i]);
        chk("dq", i, 32'(dq_m[i]), 32'(edq));
        if (ph) chk("sram_addr", i, 32'(sa[i]), 32'(ea));
        if (!ce_n[i] && !we_n[i]) begin
          if (!lb_n[i]) mem[i][sa[i][5:0]][7:0] = dq_m[i][7:0];
          if (!ub_n[i]) mem[i][sa[i][5:0]][15:8] = dq_m[i][15:8];
        end
        if (busy[i]) begin
          if (dn) busy[i] = 0;
          else k[i]++;
        end else if (req[i] && !rst) begin
          busy[i] = 1; k[i] = 1; mwe[i] = we; ma[i] = addr; mm[i] = bm; mwd[i] = wd;
        end
      end
    end
  end
  task automatic txn(input int i, input bit w, input logic [16:0] a, input logic [3:0] m,
                     input logic [31:0] d, output int lat, output int wl, output int ol, output int rl);
    @(posedge clk); #2;
    we = w; addr = a; bm = m; wd = d; req[i] = 1'b1;
    @(posedge clk); #2;
    req[i] = 1'b0;
    lat = 0; wl = 0; ol = 0; rl = 0;
    for (int c = 1; c <= 64 && lat == 0; c++) begin
      @(negedge clk);
      if (!we_n[i]) wl++;
      if (!oe_n[i]) ol++;
      if (!rdy[i]) rl++;
      if (ack[i]) lat = c;
    end
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    int lat, wl, ol, rl, n, na;
    int ts [3];
    @(posedge clk); #2;
    go = 1;
    repeat (2) @(posedge clk);
    #2 rst = 0;
    txn(0, 1, 17'h00010, 4'hF, 32'hDEADBEEF, lat, wl, ol, rl);
    chk("w1_lat", 0, lat, 3);
    chk("w1_we_cycles", 0, wl, 2);
    chk("w1_mem_lo", 0, 32'(mem[0][32]), 32'h0000BEEF);
    chk("w1_mem_hi", 0, 32'(mem[0][33]), 32'h0000DEAD);
    txn(0, 0, 17'h00010, 4'hF, 32'h0, lat, wl, ol, rl);
    chk("r1_lat", 0, lat, 3);
    chk("r1_oe_cycles", 0, ol, 2);
    chk("r1_rdata", 0, rdata[0], 32'hDEADBEEF);
    txn(0, 1, 17'h00010, 4'b0011, 32'h12345678, lat, wl, ol, rl);
    chk("wm_lat", 0, lat, SKIP ? 2 : 3);
    chk("wm_mem_lo", 0, 32'(mem[0][32]), 32'h00005678);
    chk("wm_mem_hi", 0, 32'(mem[0][33]), 32'h0000DEAD);
    txn(0, 0, 17'h00010, 4'hF, 32'h0, lat, wl, ol, rl);
    chk("rm_rdata", 0, rdata[0], 32'hDEAD5678);
    txn(0, 1, 17'h00010, 4'b0000, 32'hFFFFFFFF, lat, wl, ol, rl);
    chk("wz_lat", 0, lat, SKIP ? 1 : 3);
    chk("wz_we_cycles", 0, wl, SKIP ? 0 : 2);
    chk("wz_mem_lo", 0, 32'(mem[0][32]), 32'h00005678);
    chk("wz_mem_hi", 0, 32'(mem[0][33]), 32'h0000DEAD);
    chk("wz_rdata_kept", 0, rdata[0], 32'hDEAD5678);
    @(posedge clk); #2;
    we = 0; addr = 17'h00010; bm = 4'hF; req[0] = 1'b1;
    n = 0;
    for (int c = 0; c < 40 && n < 3; c++) begin
      @(negedge clk);
      if (ack[0]) begin
        ts[n] = c;
        n++;
      end
    end
    @(posedge clk); #2;
    req[0] = 1'b0;
    chk("b2b_acks", 0, n, 3);
    chk("b2b_gap1", 0, ts[1] - ts[0], 4);
    chk("b2b_gap2", 0, ts[2] - ts[1], 4);
    txn(2, 1, 17'h00005, 4'hF, 32'hCAFEF00D, lat, wl, ol, rl);
    chk("w3_lat", 2, lat, 7);
    chk("w3_we_cycles", 2, wl, 6);
    txn(2, 0, 17'h00005, 4'hF, 32'h0, lat, wl, ol, rl);
    chk("r3_lat", 2, lat, 7);
    chk("r3_oe_cycles", 2, ol, 6);
    chk("r3_busy_cycles", 2, rl, 7);
    chk("r3_rdata", 2, rdata[2], 32'hCAFEF00D);
    txn(1, 1, 17'h00003, 4'hF, 32'h11112222, lat, wl, ol, rl);
    chk("w2_lat", 1, lat, 5);
    @(posedge clk); #2;
    we = 1; addr = 17'h00003; bm = 4'hF; wd = 32'hA1B2C3D4; req[1] = 1'b1;
    @(posedge clk); #2;
    req[1] = 1'b0;
    @(posedge clk); #2;
    rst = 1;
    @(negedge clk);
    chk("rst_ready", 1, 32'(rdy[1]), 32'd1);
    chk("rst_ack", 1, 32'(ack[1]), 32'd0);
    chk("rst_strobes", 1, 32'({ce_n[1], we_n[1], oe_n[1], lb_n[1], ub_n[1]}), 32'h1F);
    chk("rst_dq_released", 1, 32'(dq_m[1]), 32'(PULL));
    chk("rst_rdata", 0, rdata[0], 32'h0);
    @(posedge clk); #2;
    rst = 0;
    na = 0;
    repeat (8) begin
      @(negedge clk);
      if (ack[1]) na++;
    end
    chk("rst_no_ack", 1, na, 0);
    chk("rst_mem_lo_kept", 1, 32'(mem[1][6]), 32'h0000C3D4);
    chk("rst_mem_hi_old", 1, 32'(mem[1][7]), 32'h00001111);
    txn(1, 0, 17'h00003, 4'hF, 32'h0, lat, wl, ol, rl);
    chk("r2_lat", 1, lat, 5);
    chk("r2_rdata", 1, rdata[1], 32'h1111C3D4);
    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
